// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//
// Receiver end of the neuron spike interface. It turns the registered spike
// line from a neuron's comparator stage into one spike count per window of
// WINDOW clock cycles. Each completed count is placed in a one-entry
// valid/ready output buffer. If a window completes while that buffer still
// holds an unconsumed result, the new result is lost and flagged.
//
// Parameters:
//   WINDOW     window length in clock cycles (>= 2)
//   COUNT_W    width of the spike count / rate output
//   EDGE_MODE  1 = count rising edges of spike, 0 = count cycles with spike high
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   clear       in   synchronous active-low reset
//   enable      in   decoding enable; low = idle, partial window discarded
//   spike       in   registered spike from the neuron comparator stage
//   rate_ready  in   downstream accepts rate this cycle
//   rate        out  spike count of the last completed window (unsigned)
//   rate_valid  out  rate holds an unconsumed result
//   rate_sat    out  buffered count saturated; qualified by rate_valid
//   drop        out  one-cycle pulse: window completed while buffer full

module spike_rate_decoder #(
  parameter int WINDOW    = 16,
  parameter int COUNT_W   = 8,
  parameter int EDGE_MODE = 1
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               enable,
  input  logic               spike,
  input  logic               rate_ready,
  output logic [COUNT_W-1:0] rate,
  output logic               rate_valid,
  output logic               rate_sat,
  output logic               drop
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t             state;
  logic [WIN_W-1:0]   win_cnt;
  logic [COUNT_W-1:0] spk_cnt;
  logic               sat;
  logic               spike_d;

  logic               spk_event;
  logic               blocked;
  logic [COUNT_W-1:0] cnt_next;
  logic               sat_next;
  logic               win_last;

  // Count this cycle's event into the running total. Once the counter sits at
  // its maximum, further events are blocked and remembered in the sat flag,
  // so cnt_next/sat_next are also the final values on the last window cycle.
  always_comb begin
    spk_event = (EDGE_MODE != 0) ? (spike & ~spike_d) : spike;
    blocked   = spk_event && (spk_cnt == COUNT_MAX);
    cnt_next  = (spk_event && !blocked) ? spk_cnt + COUNT_W'(1) : spk_cnt;
    sat_next  = sat | blocked;
    win_last  = (win_cnt == WIN_LAST);
  end

  // Window FSM plus the one-entry output buffer. The consume is written before
  // the window-end load so a simultaneous consume and load keeps rate_valid high.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state      <= IDLE;
      win_cnt    <= '0;
      spk_cnt    <= '0;
      sat        <= 1'b0;
      spike_d    <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      rate_sat   <= 1'b0;
      drop       <= 1'b0;
    end else begin
      spike_d <= spike;
      drop    <= 1'b0;

      if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // The transition cycle itself is never counted.
          if (enable) begin
            state   <= COUNT;
            win_cnt <= '0;
            spk_cnt <= '0;
            sat     <= 1'b0;
          end
        end

        COUNT: begin
          if (!enable) begin
            // Abort: the partial window is thrown away, buffer untouched.
            state   <= IDLE;
            win_cnt <= '0;
            spk_cnt <= '0;
            sat     <= 1'b0;
          end else if (win_last) begin
            // Window end: restart immediately so windows run back to back.
            win_cnt <= '0;
            spk_cnt <= '0;
            sat     <= 1'b0;
            if (!rate_valid || rate_ready) begin
              rate       <= cnt_next;
              rate_sat   <= sat_next;
              rate_valid <= 1'b1;
            end else begin
              drop <= 1'b1;
            end
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            spk_cnt <= cnt_next;
            sat     <= sat_next;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder
//
// Drives three spike_rate_decoder instances with one shared stimulus stream:
//   index 0: EDGE_MODE=1, COUNT_W=8
//   index 1: EDGE_MODE=0, COUNT_W=8
//   index 2: EDGE_MODE=0, COUNT_W=3 (saturates at 7)
// All use WINDOW=16, so the handshake timing is identical across instances
// and one scoreboard entry carries the expected result of all three.

module tb_spike_rate_decoder;

  logic clk;
  logic clear;
  logic enable;
  logic spike;
  logic rate_ready;

  logic [7:0] rateE;
  logic [7:0] rateL;
  logic [2:0] rateS;
  logic [2:0] validV;
  logic [2:0] satV;
  logic [2:0] dropV;

  logic [7:0] obsRate [3];

  typedef struct packed {
    logic [2:0][7:0] r;
    logic [2:0]      s;
  } exp_t;

  exp_t expQ [$];

  int testCount;
  int failCount;
  int dropCnt [3];
  logic lastSpike;

  spike_rate_decoder #(.WINDOW(16), .COUNT_W(8), .EDGE_MODE(1)) dutE (
    .clk(clk), .clear(clear), .enable(enable), .spike(spike),
    .rate_ready(rate_ready), .rate(rateE), .rate_valid(validV[0]),
    .rate_sat(satV[0]), .drop(dropV[0])
  );

  spike_rate_decoder #(.WINDOW(16), .COUNT_W(8), .EDGE_MODE(0)) dutL (
    .clk(clk), .clear(clear), .enable(enable), .spike(spike),
    .rate_ready(rate_ready), .rate(rateL), .rate_valid(validV[1]),
    .rate_sat(satV[1]), .drop(dropV[1])
  );

  spike_rate_decoder #(.WINDOW(16), .COUNT_W(3), .EDGE_MODE(0)) dutS (
    .clk(clk), .clear(clear), .enable(enable), .spike(spike),
    .rate_ready(rate_ready), .rate(rateS), .rate_valid(validV[2]),
    .rate_sat(satV[2]), .drop(dropV[2])
  );

  assign obsRate[0] = rateE;
  assign obsRate[1] = rateL;
  assign obsRate[2] = {5'b00000, rateS};

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against the run never ending.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one clock cycle of inputs; returns 1 time unit after the posedge.
  task automatic applyStimulus(input logic en, input logic sp, input logic rdy);
    enable     = en;
    spike      = sp;
    rate_ready = rdy;
    @(posedge clk);
    #1;
    lastSpike = sp;
  endtask

  // Run one full counting window. pat[i] is spike and rdyPat[i] is rate_ready
  // in window cycle i. Expected counts come from the pattern itself.
  task automatic runWindow(input logic [15:0] pat, input logic [15:0] rdyPat,
                           input bit push, input bit chkLat, input bit expDrop);
    int   eCnt;
    int   lCnt;
    logic prev;
    exp_t e;
    eCnt = 0;
    lCnt = 0;
    prev = lastSpike;
    for (int i = 0; i < 16; i++) begin
      if (pat[i] && !prev) eCnt++;
      if (pat[i]) lCnt++;
      prev = pat[i];
    end
    e.r[0] = 8'(eCnt);
    e.s[0] = 1'b0;
    e.r[1] = 8'(lCnt);
    e.s[1] = 1'b0;
    e.r[2] = (lCnt > 7) ? 8'd7 : 8'(lCnt);
    e.s[2] = (lCnt > 7);
    if (push) expQ.push_back(e);

    for (int i = 0; i < 16; i++) begin
      if (chkLat && i == 15) begin
        for (int k = 0; k < 3; k++)
          checkOutput($sformatf("valid before window end [%0d]", k), 32'(validV[k]), 32'd0);
      end
      applyStimulus(1'b1, pat[i], rdyPat[i]);
    end

    if (chkLat) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("valid at window end [%0d]", k), 32'(validV[k]), 32'd1);
        checkOutput($sformatf("rate at window end [%0d]", k), 32'(obsRate[k]), 32'(e.r[k]));
        checkOutput($sformatf("sat at window end [%0d]", k), 32'(satV[k]), 32'(e.s[k]));
      end
    end
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("drop at window end [%0d]", k), 32'(dropV[k]), 32'(expDrop));
  endtask

  // Scoreboard side: on every handshake pop the expected entry and compare
  // all three instances; also count drop cycles.
  always @(negedge clk) begin : monitor
    exp_t cur;
    if (clear === 1'b1) begin
      for (int k = 0; k < 3; k++)
        if (dropV[k] === 1'b1) dropCnt[k]++;
      if (rate_ready === 1'b1 && validV !== 3'b000) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected rate_valid", 32'(validV), 32'd0);
        end else begin
          cur = expQ.pop_front();
          for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("handshake valid [%0d]", k), 32'(validV[k]), 32'd1);
            checkOutput($sformatf("handshake rate [%0d]", k), 32'(obsRate[k]), 32'(cur.r[k]));
            checkOutput($sformatf("handshake sat [%0d]", k), 32'(satV[k]), 32'(cur.s[k]));
          end
        end
      end
    end
  end

  initial begin
    testCount  = 0;
    failCount  = 0;
    dropCnt    = '{0, 0, 0};
    lastSpike  = 1'b0;
    clear      = 1'b0;
    enable     = 1'b0;
    spike      = 1'b0;
    rate_ready = 1'b0;

    // Initial reset, then preload the output buffer with a held result.
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    runWindow(16'h1111, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Reset with busy inputs discards the buffered result.
    clear = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset rate [%0d]", k), 32'(obsRate[k]), 32'd0);
      checkOutput($sformatf("reset valid [%0d]", k), 32'(validV[k]), 32'd0);
      checkOutput($sformatf("reset sat [%0d]", k), 32'(satV[k]), 32'd0);
      checkOutput($sformatf("reset drop [%0d]", k), 32'(dropV[k]), 32'd0);
    end

    // Release: transition cycle, then first result WINDOW+1 cycles later.
    clear = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    runWindow(16'h1111, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    runWindow(16'h1111, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Spike held high, then a silent window, then last-cycle-only spike.
    runWindow(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    runWindow(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    runWindow(16'h8000, 16'hFFFF, 1'b1, 1'b1, 1'b0);

    // Buffer pressure: hold a result of 3, then lose the next one.
    runWindow(16'h0222, 16'h0001, 1'b1, 1'b0, 1'b0);
    runWindow(16'h1111, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Ready only in the last cycle: consume and reload together.
    runWindow(16'h0055, 16'h8000, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reload valid [%0d]", k), 32'(validV[k]), 32'd1);
      checkOutput($sformatf("reload rate [%0d]", k), 32'(obsRate[k]), 32'd4);
    end

    // Abort at win_cnt=7: no result, no drop, buffer retained.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("abort valid [%0d]", k), 32'(validV[k]), 32'd1);
      checkOutput($sformatf("abort rate [%0d]", k), 32'(obsRate[k]), 32'd4);
      checkOutput($sformatf("abort drop [%0d]", k), 32'(dropV[k]), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("consumed valid [%0d]", k), 32'(validV[k]), 32'd0);

    // Re-enable: a full fresh window is counted.
    applyStimulus(1'b1, 1'b0, 1'b0);
    runWindow(16'h0F0F, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a window with a result buffered.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    clear = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("mid reset rate [%0d]", k), 32'(obsRate[k]), 32'd0);
      checkOutput($sformatf("mid reset valid [%0d]", k), 32'(validV[k]), 32'd0);
      checkOutput($sformatf("mid reset sat [%0d]", k), 32'(satV[k]), 32'd0);
      checkOutput($sformatf("mid reset drop [%0d]", k), 32'(dropV[k]), 32'd0);
    end
    clear = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runWindow(16'h1111, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("drop cycles [%0d]", k), 32'(dropCnt[k]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Receiver end of the neuron spike interface. It consumes the registered spike line produced by a neuron's comparator/flip-flop stage and decodes the spike train into a spike count per fixed window of clock cycles. Each completed window count is presented on a one-entry valid/ready output buffer for downstream readout or learning logic. Handles saturation, back-to-back windows, and results dropped because the buffer is still full.

Parameters:
WINDOW, 16, window length in clock cycles (>=2)
COUNT_W, 8, width of the spike count / rate output
EDGE_MODE, 1, 1 = count rising edges of spike; 0 = count cycles with spike high

Ports:
clk  input  1  system clock, all logic on posedge
clear  input  1  synchronous active-low reset
enable  input  1  decoding enable; low = idle, partial window discarded
spike  input  1  registered spike from the neuron comparator stage
rate_ready  input  1  downstream accepts rate this cycle
rate  output  COUNT_W  spike count of the last completed window (unsigned)
rate_valid  output  1  rate holds an unconsumed result
rate_sat  output  1  count of the buffered result saturated; qualified by rate_valid
drop  output  1  one-cycle pulse: window completed while buffer full, result lost

Behaviour:
- Reset: clear==0 at posedge sets state=IDLE, win_cnt=0, spk_cnt=0, spike_d=0, rate=0, rate_valid=0, rate_sat=0, drop=0. Reset overrides all other inputs and discards any buffered result.
- spike_d <= spike every cycle in all states. event = EDGE_MODE ? (spike & ~spike_d) : spike.
- FSM states: IDLE, COUNT.
- IDLE: enable==1 -> COUNT next cycle, with win_cnt=0 and spk_cnt=0. An event in the transition cycle is not counted.
- COUNT, enable==1, each cycle:
  - spk_cnt += event, saturating at 2^COUNT_W-1. A sat bit is set when an increment is blocked.
  - win_cnt increments.
  - When win_cnt==WINDOW-1 (the last window cycle), the final count includes this cycle's event.
  - Window end with buffer free or draining (!rate_valid or rate_ready): next cycle rate=final count, rate_sat=sat, rate_valid=1.
  - Window end with buffer full (rate_valid && !rate_ready): buffer unchanged and drop=1 for exactly the next cycle.
  - At window end, win_cnt, spk_cnt and sat clear and counting continues with no gap cycle (back-to-back windows).
- COUNT with enable==0: go to IDLE and discard the partial window. The output buffer is unaffected.
- Output handshake:
  - rate_valid && rate_ready at posedge consumes the result; rate_valid -> 0 unless a new result loads the same cycle.
  - Simultaneous consume and window end: the new result loads, rate_valid stays 1, no drop.
  - rate and rate_sat are stable while rate_valid && !rate_ready.
  - rate_ready is ignored when rate_valid==0.
- Latency:
  - An event in the last window cycle appears in rate one cycle later.
  - The first result appears WINDOW+1 cycles after the cycle in which enable was first sampled high.
- drop is 0 in all cycles except the single drop pulse. No internal drop counter.
- Widths: the count uses COUNT_W bits unsigned with no wrap-around. WINDOW > 2^COUNT_W-1 is legal because saturation handles overflow.

Test Plan:
- Reset: clear=0 for 2 cycles with spike=1, enable=1, valid buffer preloaded -> rate=0, rate_valid=0, rate_sat=0, drop=0. IDLE on release; first result WINDOW+1 cycles after enable is sampled.
- EDGE_MODE=1, WINDOW=16, rate_ready=1: 1-cycle spike pulse every 4 cycles (4 pulses per window) -> rate=4, rate_valid high 1 cycle per window, rate_sat=0. Repeated with no gap between windows.
- spike held high for a full window -> EDGE_MODE=1 gives rate=1; EDGE_MODE=0 gives rate=16. Spike high in the last window cycle only (EDGE_MODE=0) -> rate=1, valid the next cycle.
- COUNT_W=3, EDGE_MODE=0, WINDOW=16, spike constant 1 -> rate=7, rate_sat=1. The next window with spike=0 -> rate=0, rate_sat=0.
- Buffer pressure, rate_ready=0:
  - First window result (3) is held.
  - Second window ends -> drop=1 for one cycle, rate still 3.
  - rate_ready=1 -> rate_valid falls.
  - ready asserted exactly at a window end -> new value loads, valid stays 1, drop=0.
- Mid-window abort: enable 1->0 at win_cnt=7 -> no result and no drop; buffered valid result retained. Re-enable -> full fresh window counted. clear=0 mid-window -> everything zeroed.
